// File: rtl/fc_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fc_layer_seq
//  Description : Time-multiplexed fully-connected layer. N_PAR MAC lanes are
//                reused over N_OUT/N_PAR passes to compute
//                d_out[o] = sat(bias[o] + sum_i (d_in[i]*W[o][i]) >>> FRAC),
//                with optional ReLU and a running argmax (out_class).
//                The weight memory is loaded and updated through the write
//                port. Its layout is row-major: W[o][0..N_IN-1], then bias[o].
//                Vector packing is element k at bits [k*DW +: DW].
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_seq #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int N_PAR = 1,
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int ACC_W = DW + 16,
  parameter bit RELU  = 1'b0,
  localparam int c_depth = N_OUT * (N_IN + 1),
  localparam int c_aw    = (c_depth > 1) ? $clog2(c_depth) : 1,
  localparam int c_cw    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*DW-1:0]    d_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*DW-1:0]   d_out,
  output logic [c_cw-1:0]       out_class,
  input  logic                  wr_en,
  input  logic [c_aw-1:0]       wr_addr,
  input  logic [DW-1:0]         wr_data,
  output logic                  wr_err
);

  localparam int c_passes = N_OUT / N_PAR;
  localparam int c_pw     = (c_passes > 1) ? $clog2(c_passes) : 1;
  localparam int c_iw     = (N_IN > 1) ? $clog2(N_IN) : 1;
  // Working width for sums: wide enough for a full product plus headroom.
  localparam int c_sw     = ((2 * DW > ACC_W) ? 2 * DW : ACC_W) + 1;

  localparam logic signed [c_sw-1:0] c_acc_max = $signed({{(c_sw-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
  localparam logic signed [c_sw-1:0] c_acc_min = $signed({{(c_sw-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});
  localparam logic signed [c_sw-1:0] c_dw_max  = $signed({{(c_sw-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [c_sw-1:0] c_dw_min  = $signed({{(c_sw-DW+1){1'b1}}, {(DW-1){1'b0}}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WRB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_pw-1:0]        r_pass;
  logic [c_iw-1:0]        r_idx;
  logic signed [DW-1:0]   r_x    [N_IN];
  logic signed [ACC_W-1:0] r_acc [N_PAR];
  logic [DW-1:0]          r_dout [N_OUT];
  logic signed [DW-1:0]   r_max;
  logic [c_cw-1:0]        r_class;
  logic                   r_out_valid;
  logic                   r_wr_err;
  logic [DW-1:0]          r_mem  [c_depth];

  logic signed [ACC_W-1:0] w_acc_next [N_PAR];
  logic signed [DW-1:0]    w_res      [N_PAR];
  logic [c_cw-1:0]         w_oidx     [N_PAR];
  logic signed [DW-1:0]    w_max_n;
  logic [c_cw-1:0]         w_cls_n;
  logic                    w_wr_hit;
  logic                    w_wr_ok;

  // Out-of-range addresses are ignored entirely (no write, no error).
  assign w_wr_hit = wr_en && (int'(wr_addr) < c_depth);
  assign w_wr_ok  = w_wr_hit && (r_state == S_IDLE) && rst;

  // Weight memory: no reset so contents survive a reset; read is combinational.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_addr] <= wr_data;
  end

  for (genvar l = 0; l < N_PAR; l++) begin : g_lane
    logic [c_aw-1:0]        w_waddr;
    logic [c_aw-1:0]        w_baddr;
    logic signed [DW-1:0]   w_wt;
    logic signed [DW-1:0]   w_bias;
    logic signed [2*DW-1:0] w_prod;
    logic signed [c_sw-1:0] w_term;
    logic signed [c_sw-1:0] w_asum;
    logic signed [c_sw-1:0] w_bsum;
    logic signed [DW-1:0]   w_sat;

    assign w_oidx[l] = c_cw'(int'(r_pass) * N_PAR + l);
    assign w_waddr   = c_aw'((int'(r_pass) * N_PAR + l) * (N_IN + 1) + int'(r_idx));
    assign w_baddr   = c_aw'((int'(r_pass) * N_PAR + l) * (N_IN + 1) + N_IN);
    assign w_wt      = r_mem[w_waddr];
    assign w_bias    = r_mem[w_baddr];

    // Full-width signed product, arithmetic shift (truncates toward -inf).
    assign w_prod = r_x[r_idx] * w_wt;
    assign w_term = $signed({{(c_sw-2*DW){w_prod[2*DW-1]}}, w_prod}) >>> FRAC;
    assign w_asum = $signed({{(c_sw-ACC_W){r_acc[l][ACC_W-1]}}, r_acc[l]}) + w_term;

    // The accumulator saturates rather than wraps so extreme inputs still
    // land on the correct rail after the final saturation.
    assign w_acc_next[l] = (w_asum > c_acc_max) ? c_acc_max[ACC_W-1:0] :
                           (w_asum < c_acc_min) ? c_acc_min[ACC_W-1:0] :
                                                  w_asum[ACC_W-1:0];

    assign w_bsum = $signed({{(c_sw-ACC_W){r_acc[l][ACC_W-1]}}, r_acc[l]})
                  + $signed({{(c_sw-DW){w_bias[DW-1]}}, w_bias});
    assign w_sat  = (w_bsum > c_dw_max) ? c_dw_max[DW-1:0] :
                    (w_bsum < c_dw_min) ? c_dw_min[DW-1:0] :
                                          w_bsum[DW-1:0];
    assign w_res[l] = (RELU && w_sat[DW-1]) ? '0 : w_sat;
  end

  // Running argmax over lanes in ascending order; first output of a frame seeds it.
  always_comb begin
    w_max_n = r_max;
    w_cls_n = r_class;
    for (int l = 0; l < N_PAR; l++) begin
      if (((r_pass == '0) && (l == 0)) || (w_res[l] > w_max_n)) begin
        w_max_n = w_res[l];
        w_cls_n = w_oidx[l];
      end
    end
  end

  // Control FSM, datapath registers and sticky write-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pass      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_class     <= '0;
      r_max       <= '0;
      r_wr_err    <= 1'b0;
      for (int l = 0; l < N_PAR; l++) r_acc[l]  <= '0;
      for (int o = 0; o < N_OUT; o++) r_dout[o] <= '0;
      for (int i = 0; i < N_IN; i++)  r_x[i]    <= '0;
    end else begin
      if (w_wr_hit && (r_state != S_IDLE)) r_wr_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= d_in[i*DW +: DW];
            for (int l = 0; l < N_PAR; l++) r_acc[l] <= '0;
            r_pass  <= '0;
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          for (int l = 0; l < N_PAR; l++) r_acc[l] <= w_acc_next[l];
          if (r_idx == c_iw'(N_IN - 1)) r_state <= S_WRB;
          else                          r_idx   <= r_idx + c_iw'(1);
        end
        S_WRB: begin
          for (int l = 0; l < N_PAR; l++) r_dout[w_oidx[l]] <= w_res[l];
          r_max   <= w_max_n;
          r_class <= w_cls_n;
          if (r_pass == c_pw'(c_passes - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            for (int l = 0; l < N_PAR; l++) r_acc[l] <= '0;
            r_pass  <= r_pass + c_pw'(1);
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    assign d_out[o*DW +: DW] = r_dout[o];
  end

  assign in_ready  = (r_state == S_IDLE) && rst;
  assign out_valid = r_out_valid;
  assign out_class = r_class;
  assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_layer_seq
//  Description : Self-checking bench for fc_layer_seq (default parameters)
//                against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_seq;

  localparam int NI = 16;
  localparam int NO = 10;
  localparam int DEPTH = NO * (NI + 1);
  localparam longint ACC_MAX = (longint'(1) <<< 47) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< 47);
  localparam longint DW_MAX  = 64'sd2147483647;
  localparam longint DW_MIN  = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NI*32-1:0] d_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NO*32-1:0] d_out;
  logic [3:0]      out_class;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_addr = '0;
  logic [31:0]     wr_data = '0;
  logic            wr_err;

  fc_layer_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .out_class(out_class),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] xin   [NI];
  logic [31:0] y_m   [NO];
  int          cls_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: dot product in 64-bit integers, clamped accumulator, bias, clamp.
  function automatic void compute_model();
    longint acc, p, best;
    for (int o = 0; o < NO; o++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) begin
        p = longint'($signed(xin[i])) * longint'($signed(mem_m[o*(NI+1)+i]));
        acc += (p >>> 16);
        if (acc > ACC_MAX) acc = ACC_MAX;
        if (acc < ACC_MIN) acc = ACC_MIN;
      end
      acc += longint'($signed(mem_m[o*(NI+1)+NI]));
      if (acc > DW_MAX) acc = DW_MAX;
      if (acc < DW_MIN) acc = DW_MIN;
      y_m[o] = acc[31:0];
    end
    cls_m = 0;
    best = longint'($signed(y_m[0]));
    for (int o = 1; o < NO; o++)
      if (longint'($signed(y_m[o])) > best) begin
        best  = longint'($signed(y_m[o]));
        cls_m = o;
      end
  endfunction

  task automatic wr_word(input int addr, input logic [31:0] data, input bit upd);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr[7:0];
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (upd && addr < DEPTH) mem_m[addr] = data;
  endtask

  task automatic load_t1();
    for (int o = 0; o < NO; o++)
      for (int i = 0; i <= NI; i++)
        wr_word(o*(NI+1)+i, (i == NI) ? (32'(o) << 16) : 32'h0001_0000, 1'b1);
    for (int i = 0; i < NI; i++) xin[i] = 32'h0001_0000;
  endtask

  // Accept a frame at the next edge; optionally write one word in the same cycle.
  task automatic start_frame(input bit do_wr, input int addr, input logic [31:0] data);
    @(negedge clk);
    chk("accept_in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < NI; i++) d_in[i*32 +: 32] = xin[i];
    in_valid = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = addr[7:0]; wr_data = data;
      mem_m[addr] = data;
    end
    compute_model();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wr_en    = 1'b0;
    d_in     = {NI*32{1'b1}};
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 1000);
    if (!out_valid) chk("timeout_out_valid", 64'd0, 64'd1);
  endtask

  task automatic check_result(input string tag);
    for (int o = 0; o < NO; o++)
      chk($sformatf("%s d_out[%0d]", tag, o), {32'b0, d_out[o*32 +: 32]}, {32'b0, y_m[o]});
    chk({tag, " out_class"}, {60'b0, out_class}, 64'(cls_m));
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_out_valid_drop", {63'b0, out_valid}, 64'd0);
    chk("hs_in_ready", {63'b0, in_ready}, 64'd1);
  endtask

  task automatic full_frame(input string tag, input int exp_lat);
    int lat;
    start_frame(1'b0, 0, 32'h0);
    wait_result(lat);
    if (exp_lat > 0) chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_result(tag);
    handshake();
  endtask

  initial begin
    int lat;
    int bad;
    logic [NO*32-1:0] snap;

    // Reset state
    #12;
    chk("rst_in_ready_low", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_wr_err", {63'b0, wr_err}, 64'd0);
    chk("rst_dout_zero", {63'b0, |d_out}, 64'd0);
    chk("rst_out_class", {60'b0, out_class}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Out-of-range write in IDLE is ignored
    wr_word(200, 32'hDEAD_BEEF, 1'b0);
    chk("oor_idle_wr_err", {63'b0, wr_err}, 64'd0);

    // T1: unit weights, bias o<<16
    load_t1();
    full_frame("t1", 170);
    chk("t1_dout9_const", {32'b0, d_out[9*32 +: 32]}, 64'h0019_0000);

    // T5: bias[3] rewrite
    wr_word(67, 32'h0064_0000, 1'b1);
    full_frame("t5", 170);
    chk("t5_dout3_const", {32'b0, d_out[3*32 +: 32]}, 64'h0074_0000);
    chk("t5_class_const", {60'b0, out_class}, 64'd3);

    // Write in accept cycle takes effect; writes during MAC are dropped
    for (int i = 0; i < NI; i++) xin[i] = $urandom_range(32'h0003_0000, 0) - 32'h0001_8000;
    start_frame(1'b1, 5*(NI+1)+2, 32'h0020_0000);
    wr_word(230, 32'h1234_5678, 1'b0);
    chk("oor_mac_wr_err", {63'b0, wr_err}, 64'd0);
    wr_word(7*(NI+1)+1, 32'h7000_0000, 1'b0);
    chk("mac_wr_err_set", {63'b0, wr_err}, 64'd1);
    wait_result(lat);
    check_result("wrmac");

    // T3: backpressure with in_valid toggling
    snap = d_out;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      for (int i = 0; i < NI; i++) d_in[i*32 +: 32] = $urandom;
      @(posedge clk); #1;
      if (!out_valid || in_ready || d_out !== snap) bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
    chk("bp_wr_err_sticky", {63'b0, wr_err}, 64'd1);
    handshake();

    // T4: reset mid-frame
    load_t1();
    start_frame(1'b0, 0, 32'h0);
    repeat (49) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t4_out_valid", {63'b0, out_valid}, 64'd0);
    chk("t4_dout_zero", {63'b0, |d_out}, 64'd0);
    chk("t4_wr_err", {63'b0, wr_err}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_in_ready", {63'b0, in_ready}, 64'd1);
    full_frame("t4_t1", 170);

    // T2: positive and negative saturation
    for (int a = 0; a < DEPTH; a++) wr_word(a, ((a % (NI+1)) == NI) ? 32'h0 : 32'h7FFF_0000, 1'b1);
    for (int i = 0; i < NI; i++) xin[i] = 32'h7FFF_0000;
    full_frame("t2p", 170);
    chk("t2p_const", {32'b0, d_out[0 +: 32]}, 64'h7FFF_FFFF);
    for (int a = 0; a < DEPTH; a++) if ((a % (NI+1)) != NI) wr_word(a, 32'h8001_0000, 1'b1);
    full_frame("t2n", 170);
    chk("t2n_const", {32'b0, d_out[5*32 +: 32]}, 64'h8000_0000);

    // Randomized frames, mixing moderate and full-range magnitudes
    for (int f = 0; f < 5; f++) begin
      for (int a = 0; a < DEPTH; a++)
        wr_word(a, (f == 4) ? $urandom : ($urandom_range(32'h0004_0000, 0) - 32'h0002_0000), 1'b1);
      for (int i = 0; i < NI; i++)
        xin[i] = (f == 3) ? $urandom : ($urandom_range(32'h0100_0000, 0) - 32'h0080_0000);
      full_frame($sformatf("rnd%0d", f), 170);
    end

    // All-zero weights and biases: tie resolves to class 0
    for (int a = 0; a < DEPTH; a++) wr_word(a, 32'h0, 1'b1);
    for (int i = 0; i < NI; i++) xin[i] = $urandom;
    full_frame("zero", 170);
    chk("zero_class_const", {60'b0, out_class}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
